// File: rtl/l2_write_buffer_if.sv
// L2 memory-side bus (mem_*) and physical-memory bus (pmem_*) bundled
// together for the eviction write buffer.
//   slave  : write buffer view (takes L2 requests, issues pmem requests)
//   master : environment view (L2 cache plus physical memory)
interface l2_write_buffer_if #(
    parameter int s_line = 256
) ();
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l2_write_buffer.sv
// Eviction write buffer between the L2 memory-side port and physical memory.
// Dirty-line writebacks are absorbed into a DEPTH-entry FIFO and drained to
// pmem whenever L2 has nothing pending. Line reads that hit a buffered line
// are served from the buffer; other reads go to pmem. Repeated writebacks
// to one line coalesce into a single entry.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus (slave)     mem_* from L2, pmem_* to physical memory
//   count           number of valid entries
//   full, empty     registered count==DEPTH / count==0
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | arbitrate: read hit/miss, write hit/push, else drain head
// ACK     | one-cycle mem_resp for a buffer-served read or accepted write
// RD_MISS | pmem_read of the latched line until pmem_resp
// RD_RESP | one-cycle mem_resp with pmem data
// DRAIN   | pmem_write of the head entry until pmem_resp, then pop
module l2_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    l2_write_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int TW = 32 - s_offset;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [2:0] {IDLE, ACK, RD_MISS, RD_RESP, DRAIN} state_t;

    state_t            state, state_n;
    logic [DEPTH-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [DEPTH];
    logic [s_line-1:0] data_q [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [TW-1:0]     miss_tag;
    logic [TW-1:0]     req_tag;

    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic              do_rd_hit, do_rd_miss, do_wr_hit, do_push, do_pop, load_rdata;

    assign req_tag = bus.mem_address[31:s_offset];

    // Coalescing keeps at most one matching entry, so a priority-free scan is enough.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n          = state;
        do_rd_hit        = 1'b0;
        do_rd_miss       = 1'b0;
        do_wr_hit        = 1'b0;
        do_push          = 1'b0;
        do_pop           = 1'b0;
        load_rdata       = 1'b0;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        case (state)
            IDLE: begin
                // Reads win over a simultaneous (illegal) write.
                if (bus.mem_read) begin
                    if (hit) begin
                        do_rd_hit = 1'b1;
                        state_n   = ACK;
                    end else begin
                        do_rd_miss = 1'b1;
                        state_n    = RD_MISS;
                    end
                end else if (bus.mem_write && hit) begin
                    do_wr_hit = 1'b1;
                    state_n   = ACK;
                end else if (bus.mem_write && !full) begin
                    do_push = 1'b1;
                    state_n = ACK;
                end else if (!empty) begin
                    state_n = DRAIN;
                end
            end
            ACK: begin
                bus.mem_resp = 1'b1;
                state_n      = IDLE;
            end
            RD_MISS: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_tag, {s_offset{1'b0}}};
                if (bus.pmem_resp) begin
                    load_rdata = 1'b1;
                    state_n    = RD_RESP;
                end
            end
            RD_RESP: begin
                bus.mem_resp = 1'b1;
                state_n      = IDLE;
            end
            DRAIN: begin
                // Head entry cannot change while draining: IDLE accepts nothing here.
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[head], {s_offset{1'b0}}};
                bus.pmem_wdata   = data_q[head];
                if (bus.pmem_resp) begin
                    do_pop  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            miss_tag      <= '0;
            bus.mem_rdata <= '0;
        end else begin
            if (do_rd_hit)  bus.mem_rdata <= data_q[hit_idx];
            if (load_rdata) bus.mem_rdata <= bus.pmem_rdata;
            if (do_rd_miss) miss_tag      <= req_tag;
            if (do_wr_hit)  data_q[hit_idx] <= bus.mem_wdata;
            if (do_push) begin
                valid_q[tail] <= 1'b1;
                tag_q[tail]   <= req_tag;
                data_q[tail]  <= bus.mem_wdata;
                tail          <= tail + 1'b1;
                count         <= count + ONE_CNT;
                full          <= (count + ONE_CNT) == FULL_CNT;
                empty         <= 1'b0;
            end
            if (do_pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
                count         <= count - ONE_CNT;
                full          <= 1'b0;
                empty         <= count == ONE_CNT;
            end
        end
    end
endmodule

// File: tb/tb_l2_write_buffer.sv
module tb_l2_write_buffer;
    localparam logic [255:0] DA  = {8{32'hAAAA_0001}};
    localparam logic [255:0] DB  = {8{32'hBBBB_0002}};
    localparam logic [255:0] DC1 = {8{32'hCCCC_0001}};
    localparam logic [255:0] DC2 = {8{32'hCCCC_0002}};
    localparam logic [255:0] DD  = {8{32'hDDDD_0004}};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] count;
    logic       full, empty;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    l2_write_buffer_if #(.s_line(256)) bus ();

    l2_write_buffer #(.DEPTH(4), .s_offset(5), .s_line(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // physical memory model
    logic [255:0] mem_q [logic [31:0]];
    int           pm_lat = 3;
    bit           pm_hold = 1'b0;
    int           pm_cnt = 0;
    int           n_reads = 0, n_writes = 0;
    int           pm_resp_cyc = 0;
    logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
    end

    always begin
        @(posedge clk); #1;
        if (!rst_n) begin
            bus.pmem_resp = 1'b0;
            pm_cnt = 0;
        end else if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            pm_cnt = 0;
        end else if ((bus.pmem_read || bus.pmem_write) && !pm_hold) begin
            pm_cnt++;
            if (pm_cnt >= pm_lat) begin
                bus.pmem_resp = 1'b1;
                pm_resp_cyc = cyc;
                if (bus.pmem_write) begin
                    mem_q[bus.pmem_address] = bus.pmem_wdata;
                    last_wr_addr = bus.pmem_address;
                    last_wr_data = bus.pmem_wdata;
                    n_writes++;
                end else begin
                    last_rd_addr = bus.pmem_address;
                    bus.pmem_rdata = mem_q.exists(bus.pmem_address) ? mem_q[bus.pmem_address]
                                                                     : {8{bus.pmem_address}};
                    n_reads++;
                end
            end
        end
    end

    // Drives one L2 request, waits for mem_resp (lat=-1 on timeout), then idles one cycle.
    task automatic l2_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [255:0] d, input int max_cyc,
                          output int lat, output logic [255:0] rdata, output int resp_cyc);
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a; bus.mem_wdata = d;
        lat = -1; rdata = '0; resp_cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin
                lat = i; rdata = bus.mem_rdata; resp_cyc = cyc;
                break;
            end
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
        if (lat > 0) begin @(posedge clk); #1; end
    endtask

    task automatic wait_empty(input int max_cyc);
        for (int i = 0; i < max_cyc && !empty; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {bus.mem_resp, bus.pmem_read, bus.pmem_write});
        end
        tests_run++;
        if (bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0 || bus.mem_rdata !== 256'h0) begin
            tests_failed++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", bus.pmem_address, bus.pmem_wdata, bus.mem_rdata);
        end
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++; $display("FAIL reset_count: count %0d empty %b full %b expected 0 1 0", count, empty, full);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_drain;
        int lat, rc, nw0;
        logic [255:0] rd;
        pm_lat = 3;
        nw0 = n_writes;
        l2_req(1'b0, 1'b1, 32'h0000_1000, DA, 20, lat, rd, rc);
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 1", lat); end
        tests_run++;
        if (count !== 3'd1) begin tests_failed++; $display("FAIL wr_count: got %0d expected 1", count); end
        for (int i = 0; i < 30 && n_writes == nw0; i++) begin @(posedge clk); #1; end
        tests_run++;
        if (n_writes !== nw0 + 1 || last_wr_addr !== 32'h1000 || last_wr_data !== DA) begin
            tests_failed++; $display("FAIL drain_write: n %0d addr %h data %h expected n %0d addr 1000 data %h", n_writes - nw0, last_wr_addr, last_wr_data, 1, DA);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL drain_count: count %0d empty %b expected 0 1", count, empty); end
    endtask

    task automatic test_read_hit;
        int lat, rc, nr0;
        logic [255:0] rd;
        nr0 = n_reads;
        l2_req(1'b0, 1'b1, 32'h0000_2000, DB, 20, lat, rd, rc);
        l2_req(1'b1, 1'b0, 32'h0000_2004, '0, 20, lat, rd, rc);
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("FAIL hit_latency: got %0d expected 1", lat); end
        tests_run++;
        if (rd !== DB) begin tests_failed++; $display("FAIL hit_rdata: got %h expected %h", rd, DB); end
        wait_empty(40);
        tests_run++;
        if (n_reads !== nr0 || empty !== 1'b1) begin tests_failed++; $display("FAIL hit_no_pmem_read: reads %0d empty %b expected 0 1", n_reads - nr0, empty); end
    endtask

    task automatic test_coalesce;
        int lat, rc, nw0;
        logic [255:0] rd;
        nw0 = n_writes;
        l2_req(1'b0, 1'b1, 32'h0000_3000, DC1, 20, lat, rd, rc);
        l2_req(1'b0, 1'b1, 32'h0000_3000, DC2, 20, lat, rd, rc);
        tests_run++;
        if (count !== 3'd1 || lat !== 1) begin tests_failed++; $display("FAIL coalesce_count: count %0d lat %0d expected 1 1", count, lat); end
        wait_empty(40);
        tests_run++;
        if (n_writes !== nw0 + 1 || last_wr_addr !== 32'h3000 || last_wr_data !== DC2) begin
            tests_failed++; $display("FAIL coalesce_drain: n %0d addr %h data %h expected n 1 addr 3000 data %h", n_writes - nw0, last_wr_addr, last_wr_data, DC2);
        end
    endtask

    task automatic test_back_to_back_full;
        int lat, rc, nw0, seen, resp_at;
        logic [255:0] rd;
        logic [2:0]   cnt_at;
        nw0 = n_writes;
        pm_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            l2_req(1'b0, 1'b1, 32'(i * 32'h100), {8{32'(i) ^ 32'hDEAD_0000}}, 20, lat, rd, rc);
            tests_run++;
            if (lat !== 1) begin tests_failed++; $display("FAIL full_ack%0d: got %0d expected 1", i, lat); end
        end
        tests_run++;
        if (full !== 1'b1 || count !== 3'd4) begin tests_failed++; $display("FAIL full_flag: full %b count %0d expected 1 4", full, count); end
        bus.mem_write = 1'b1; bus.mem_address = 32'h500; bus.mem_wdata = {8{32'h5 ^ 32'hDEAD_0000}};
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (bus.mem_resp) seen++; end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL full_no_ack: got %0d responses expected 0", seen); end
        tests_run++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 32'h100 || bus.pmem_wdata !== {8{32'h1 ^ 32'hDEAD_0000}}) begin
            tests_failed++; $display("FAIL full_drain_head: wr %b addr %h expected 1 100", bus.pmem_write, bus.pmem_address);
        end
        pm_hold = 1'b0;
        resp_at = -1; cnt_at = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin resp_at = cyc; cnt_at = count; break; end
        end
        bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
        tests_run++;
        if (resp_at !== pm_resp_cyc + 2) begin tests_failed++; $display("FAIL full_accept_time: resp at %0d expected %0d", resp_at, pm_resp_cyc + 2); end
        tests_run++;
        if (cnt_at !== 3'd4) begin tests_failed++; $display("FAIL full_accept_count: got %0d expected 4", cnt_at); end
        @(posedge clk); #1;
        wait_empty(100);
        tests_run++;
        if (n_writes !== nw0 + 5 || last_wr_addr !== 32'h500 || empty !== 1'b1) begin
            tests_failed++; $display("FAIL full_drain_all: n %0d last %h empty %b expected 5 500 1", n_writes - nw0, last_wr_addr, empty);
        end
    endtask

    task automatic test_read_miss;
        int lat, rc, nr0;
        logic [255:0] rd;
        pm_lat = 5;
        mem_q[32'h4000] = DD;
        nr0 = n_reads;
        l2_req(1'b1, 1'b0, 32'h0000_4000, '0, 30, lat, rd, rc);
        tests_run++;
        if (n_reads !== nr0 + 1 || last_rd_addr !== 32'h4000) begin tests_failed++; $display("FAIL miss_pmem_read: n %0d addr %h expected 1 4000", n_reads - nr0, last_rd_addr); end
        tests_run++;
        if (rd !== DD) begin tests_failed++; $display("FAIL miss_rdata: got %h expected %h", rd, DD); end
        tests_run++;
        if (rc !== pm_resp_cyc + 1) begin tests_failed++; $display("FAIL miss_latency: resp at %0d expected %0d", rc, pm_resp_cyc + 1); end
    endtask

    task automatic test_reset_in_drain;
        int lat, rc, nr0;
        logic [255:0] rd;
        pm_hold = 1'b1;
        l2_req(1'b0, 1'b1, 32'h600, DA, 20, lat, rd, rc);
        l2_req(1'b0, 1'b1, 32'h700, DB, 20, lat, rd, rc);
        l2_req(1'b0, 1'b1, 32'h800, DD, 20, lat, rd, rc);
        for (int i = 0; i < 5 && !bus.pmem_write; i++) begin @(posedge clk); #1; end
        tests_run++;
        if (bus.pmem_write !== 1'b1 || count !== 3'd3) begin tests_failed++; $display("FAIL rst_pre_drain: wr %b count %0d expected 1 3", bus.pmem_write, count); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.pmem_write !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || bus.mem_resp !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_drain: wr %b count %0d empty %b resp %b expected 0 0 1 0", bus.pmem_write, count, empty, bus.mem_resp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pm_hold = 1'b0;
        pm_lat = 2;
        @(posedge clk); #1;
        nr0 = n_reads;
        l2_req(1'b1, 1'b0, 32'h700, '0, 30, lat, rd, rc);
        tests_run++;
        if (n_reads !== nr0 + 1 || last_rd_addr !== 32'h700 || rd !== {8{32'h700}}) begin
            tests_failed++; $display("FAIL rst_read_goes_pmem: n %0d addr %h data %h expected 1 700 %h", n_reads - nr0, last_rd_addr, rd, {8{32'h700}});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_drain();
        test_read_hit();
        test_coalesce();
        test_back_to_back_full();
        test_read_miss();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
